// File: rtl/srambank_arbiter_if.sv
// Request/response and bank-side bus bundle for srambank_arbiter.
//   i_req_valid/i_req_write/i_req_addr/i_req_wdata : requester -> arbiter, field r per requester
//   o_req_ready                                     : per-requester grant
//   o_rsp_valid/o_rsp_data                          : read response, one cycle after acceptance
//   o_bank_*                                        : per-bank select, enables, row address, write data
//   i_bank_data_out                                 : registered read data from each bank
//   o_conflicts                                     : saturating count of conflict cycles
// The arbiter connects through the slave modport; the requester/bank side uses master.
interface srambank_arbiter_if #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned BANKS   = 4,
  parameter int unsigned ADDRESS = 9,
  parameter int unsigned DATA    = 18
);
  localparam int unsigned BB = $clog2(BANKS);
  localparam int unsigned AW = BB + ADDRESS;

  logic [NREQ-1:0]          i_req_valid;
  logic [NREQ-1:0]          i_req_write;
  logic [NREQ*AW-1:0]       i_req_addr;
  logic [NREQ*DATA-1:0]     i_req_wdata;
  logic [NREQ-1:0]          o_req_ready;
  logic [NREQ-1:0]          o_rsp_valid;
  logic [NREQ*DATA-1:0]     o_rsp_data;
  logic [BANKS*ADDRESS-1:0] o_bank_address;
  logic [BANKS*DATA-1:0]    o_bank_write_data;
  logic [BANKS-1:0]         o_bank_sel;
  logic [BANKS-1:0]         o_bank_read_en;
  logic [BANKS-1:0]         o_bank_write_en;
  logic [BANKS*DATA-1:0]    i_bank_data_out;
  logic [15:0]              o_conflicts;

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_bank_data_out,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_bank_address, o_bank_write_data,
    output o_bank_sel, o_bank_read_en, o_bank_write_en, o_conflicts
  );

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_bank_data_out,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_bank_address, o_bank_write_data,
    input  o_bank_sel, o_bank_read_en, o_bank_write_en, o_conflicts
  );
endinterface

// File: rtl/srambank_arbiter.sv
// Multi-requester front end for a group of single-port SRAM banks.
// Each cycle every bank grants at most one requester using its own round-robin
// pointer; the bank is driven combinationally in the same cycle as the grant and
// read data is routed back to the issuing requester one cycle later.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset; also blanks grants, bank drive and
//            responses combinationally while asserted
//   bus    : srambank_arbiter_if.slave (requests, responses, bank lines, conflict count)
module srambank_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned BANKS   = 4,
  parameter int unsigned ADDRESS = 9,
  parameter int unsigned DATA    = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  srambank_arbiter_if.slave bus
);
  localparam int unsigned BB = $clog2(BANKS);
  localparam int unsigned AW = BB + ADDRESS;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 16;

  logic [BB-1:0]      req_bank  [NREQ];
  logic [ADDRESS-1:0] req_row   [NREQ];
  logic [DATA-1:0]    req_wdata [NREQ];
  logic [DATA-1:0]    bank_dout [BANKS];

  logic [NREQ-1:0]    cand      [BANKS];
  logic [BANKS-1:0]   bank_gnt;
  logic [BANKS-1:0]   bank_multi;
  logic [PW-1:0]      bank_win  [BANKS];
  logic [NREQ-1:0]    req_ready_c;

  logic [PW-1:0]      ptr_q   [BANKS];
  logic [PW-1:0]      ptr_d   [BANKS];
  logic [NREQ-1:0]    pend_q, pend_d;
  logic [BB-1:0]      pbank_q [NREQ];
  logic [BB-1:0]      pbank_d [NREQ];
  logic [CW-1:0]      conf_q, conf_d;

  // Split the flat request and bank-data buses into per-field arrays.
  always_comb begin : unpack
    for (int r = 0; r < int'(NREQ); r++) begin
      req_bank[r]  = bus.i_req_addr[r*AW + ADDRESS +: BB];
      req_row[r]   = bus.i_req_addr[r*AW +: ADDRESS];
      req_wdata[r] = bus.i_req_wdata[r*DATA +: DATA];
    end
    for (int b = 0; b < int'(BANKS); b++) begin
      bank_dout[b] = bus.i_bank_data_out[b*DATA +: DATA];
    end
  end

  // Candidate matrix: requester r is valid and targets bank b.
  always_comb begin : candidates
    for (int b = 0; b < int'(BANKS); b++) begin
      cand[b] = '0;
      for (int r = 0; r < int'(NREQ); r++) begin
        cand[b][r] = bus.i_req_valid[r] && (req_bank[r] == BB'(b));
      end
    end
  end

  // Round-robin search from ptr[b] upward; first candidate wins.
  always_comb begin : arbitrate
    int idx;
    idx        = 0;
    bank_gnt   = '0;
    bank_multi = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      bank_win[b] = '0;
    end
    for (int b = 0; b < int'(BANKS); b++) begin
      bank_multi[b] = ($countones(cand[b]) > 1);
      for (int k = 0; k < int'(NREQ); k++) begin
        idx = (int'(ptr_q[b]) + k) % int'(NREQ);
        if (!bank_gnt[b] && cand[b][idx]) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = PW'(idx);
        end
      end
    end
  end

  // Grants and bank drive; everything idles to zero during reset.
  always_comb begin : drive
    req_ready_c           = '0;
    bus.o_bank_sel        = '0;
    bus.o_bank_read_en    = '0;
    bus.o_bank_write_en   = '0;
    bus.o_bank_address    = '0;
    bus.o_bank_write_data = '0;
    if (!i_rst) begin
      for (int b = 0; b < int'(BANKS); b++) begin
        if (bank_gnt[b]) begin
          req_ready_c[bank_win[b]]                = 1'b1;
          bus.o_bank_sel[b]                       = 1'b1;
          bus.o_bank_write_en[b]                  = bus.i_req_write[bank_win[b]];
          bus.o_bank_read_en[b]                   = ~bus.i_req_write[bank_win[b]];
          bus.o_bank_address[b*ADDRESS +: ADDRESS] = req_row[bank_win[b]];
          bus.o_bank_write_data[b*DATA +: DATA]   = req_wdata[bank_win[b]];
        end
      end
    end
    bus.o_req_ready = req_ready_c;
  end

  // Route each pending read back from the bank it was issued to.
  always_comb begin : respond
    bus.o_rsp_valid = '0;
    bus.o_rsp_data  = '0;
    if (!i_rst) begin
      for (int r = 0; r < int'(NREQ); r++) begin
        if (pend_q[r]) begin
          bus.o_rsp_valid[r]             = 1'b1;
          bus.o_rsp_data[r*DATA +: DATA] = bank_dout[pbank_q[r]];
        end
      end
    end
  end

  // Pointer advance past the winner, read tracking, saturating conflict count.
  always_comb begin : next_state
    ptr_d  = ptr_q;
    pend_d = '0;
    conf_d = conf_q;
    for (int b = 0; b < int'(BANKS); b++) begin
      if (bank_gnt[b]) begin
        ptr_d[b] = (bank_win[b] == PW'(NREQ - 1)) ? '0 : bank_win[b] + PW'(1);
      end
    end
    for (int r = 0; r < int'(NREQ); r++) begin
      pend_d[r]  = req_ready_c[r] & ~bus.i_req_write[r];
      pbank_d[r] = req_bank[r];
    end
    if ((|bank_multi) && (conf_q != '1)) begin
      conf_d = conf_q + CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < int'(BANKS); b++) begin
        ptr_q[b] <= '0;
      end
      pend_q <= '0;
      conf_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
      conf_q <= conf_d;
    end
    pbank_q <= pbank_d;
  end

  assign bus.o_conflicts = conf_q;
endmodule
